// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes every datapath control from the current state, opcode, funct and zero flag.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RFWr,
    output logic       wren,
    output logic [1:0] npcop,
    output logic [3:0] aluop,
    output logic       sel,
    output logic [1:0] extop,
    output logic [1:0] D_sel,
    output logic [1:0] R_sel,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH = 4'd0,
        DCD   = 4'd1,
        EXE   = 4'd2,
        WB    = 4'd3,
        MA    = 4'd4,
        MR    = 4'd5,
        LWB   = 4'd6,
        MW    = 4'd7,
        BR    = 4'd8,
        JMP   = 4'd9,
        JAL   = 4'd10,
        JR    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [3:0] ALU_ADDU = 4'b0000;
    localparam logic [3:0] ALU_SUBU = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;

    state_t cur_state, next_state;

    logic       is_rtype;
    logic       r_valid;
    logic       imm_valid;
    logic [3:0] exe_aluop;
    logic       exe_sel;
    logic [1:0] exe_extop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur_state <= FETCH;
        else      cur_state <= next_state;
    end

    assign is_rtype = (op == OP_RTYPE);
    assign state    = cur_state;

    // ALU controls shared by EXE and WB, plus validity of the ALU-class instructions.
    always_comb begin
        exe_aluop = ALU_ADDU;
        exe_sel   = 1'b0;
        exe_extop = 2'b00;
        r_valid   = 1'b0;
        imm_valid = 1'b0;
        if (is_rtype) begin
            r_valid = 1'b1;
            case (funct)
                FN_ADDU: exe_aluop = ALU_ADDU;
                FN_SUBU: exe_aluop = ALU_SUBU;
                FN_AND:  exe_aluop = ALU_AND;
                FN_OR:   exe_aluop = ALU_OR;
                FN_SLT:  exe_aluop = ALU_SLT;
                default: r_valid   = 1'b0;
            endcase
        end else begin
            imm_valid = 1'b1;
            exe_sel   = 1'b1;
            case (op)
                OP_ORI:   begin exe_aluop = ALU_OR;   exe_extop = 2'b00; end
                OP_ADDIU: begin exe_aluop = ALU_ADDU; exe_extop = 2'b01; end
                OP_LUI:   begin exe_aluop = ALU_OR;   exe_extop = 2'b10; end
                default:  begin imm_valid = 1'b0;     exe_sel   = 1'b0;  end
            endcase
        end
    end

    always_comb begin
        next_state = FETCH;
        PCWr    = 1'b0;
        IRWr    = 1'b0;
        RFWr    = 1'b0;
        wren    = 1'b0;
        npcop   = 2'b00;
        aluop   = 4'b0000;
        sel     = 1'b0;
        extop   = 2'b00;
        D_sel   = 2'b00;
        R_sel   = 2'b00;
        illegal = 1'b0;

        case (cur_state)
            FETCH: begin
                IRWr       = 1'b1;
                PCWr       = 1'b1;
                next_state = DCD;
            end
            DCD: begin
                if (is_rtype && r_valid)                  next_state = EXE;
                else if (is_rtype && funct == FN_JR)      next_state = JR;
                else if (imm_valid)                       next_state = EXE;
                else if (op == OP_LW || op == OP_SW)      next_state = MA;
                else if (op == OP_BEQ)                    next_state = BR;
                else if (op == OP_J)                      next_state = JMP;
                else if (op == OP_JAL)                    next_state = JAL;
                else                                      illegal    = 1'b1;
            end
            EXE: begin
                aluop      = exe_aluop;
                sel        = exe_sel;
                extop      = exe_extop;
                next_state = WB;
            end
            WB: begin
                aluop = exe_aluop;
                sel   = exe_sel;
                extop = exe_extop;
                RFWr  = 1'b1;
                D_sel = 2'b01;
                R_sel = is_rtype ? 2'b10 : 2'b01;
            end
            MA: begin
                aluop = ALU_ADDU;
                sel   = 1'b1;
                extop = 2'b01;
                if (op == OP_LW)      next_state = MR;
                else if (op == OP_SW) next_state = MW;
            end
            MR:  next_state = LWB;
            LWB: begin
                RFWr  = 1'b1;
                D_sel = 2'b10;
                R_sel = 2'b01;
            end
            MW:  wren = 1'b1;
            BR: begin
                aluop = ALU_SUBU;
                npcop = 2'b01;
                PCWr  = zero;
            end
            JMP: begin
                PCWr  = 1'b1;
                npcop = 2'b10;
            end
            JR: begin
                PCWr  = 1'b1;
                npcop = 2'b11;
            end
            JAL: begin
                RFWr  = 1'b1;
                PCWr  = 1'b1;
                npcop = 2'b10;
            end
            default: next_state = FETCH;
        endcase

        // Reset holds every control low even though FETCH would otherwise fire its enables.
        if (!rst) begin
            PCWr    = 1'b0;
            IRWr    = 1'b0;
            RFWr    = 1'b0;
            wren    = 1'b0;
            npcop   = 2'b00;
            aluop   = 4'b0000;
            sel     = 1'b0;
            extop   = 2'b00;
            D_sel   = 2'b00;
            R_sel   = 2'b00;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl: per-cycle table of expected state and
// controls for every instruction class, plus reset-abort sequences.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op, funct;
    logic       zero;
    logic       PCWr, IRWr, RFWr, wren, sel, illegal;
    logic [1:0] npcop, extop, D_sel, R_sel;
    logic [3:0] aluop, state;
    logic [17:0] act;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [3:0]  st;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .wren(wren),
        .npcop(npcop), .aluop(aluop), .sel(sel), .extop(extop),
        .D_sel(D_sel), .R_sel(R_sel), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign act = {PCWr, IRWr, RFWr, wren, npcop, aluop, sel, extop, D_sel, R_sel, illegal};

    function automatic logic [17:0] pk(input logic pcwr, input logic irwr, input logic rfwr,
                                       input logic wr, input logic [1:0] npc, input logic [3:0] alu,
                                       input logic s, input logic [1:0] ext, input logic [1:0] ds,
                                       input logic [1:0] rs, input logic ill);
        return {pcwr, irwr, rfwr, wr, npc, alu, s, ext, ds, rs, ill};
    endfunction

    localparam logic [17:0] FE = 18'b1100_00_0000_0_00_00_00_0;
    localparam logic [17:0] NZ = 18'd0;

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic [3:0] s, input logic [17:0] e);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.st = s; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic addFetchDcd(input logic [5:0] o, input logic [5:0] f, input logic z);
        add(o, f, z, 4'd0, FE);
        add(o, f, z, 4'd1, NZ);
    endtask

    task automatic addRtype(input logic [5:0] f, input logic [3:0] alu);
        addFetchDcd(6'b000000, f, 1'b0);
        add(6'b000000, f, 1'b0, 4'd2, pk(0, 0, 0, 0, 2'b00, alu, 0, 2'b00, 2'b00, 2'b00, 0));
        add(6'b000000, f, 1'b0, 4'd3, pk(0, 0, 1, 0, 2'b00, alu, 0, 2'b00, 2'b01, 2'b10, 0));
    endtask

    task automatic addImm(input logic [5:0] o, input logic [3:0] alu, input logic [1:0] ext);
        addFetchDcd(o, 6'b000000, 1'b0);
        add(o, 6'b000000, 1'b0, 4'd2, pk(0, 0, 0, 0, 2'b00, alu, 1, ext, 2'b00, 2'b00, 0));
        add(o, 6'b000000, 1'b0, 4'd3, pk(0, 0, 1, 0, 2'b00, alu, 1, ext, 2'b01, 2'b01, 0));
    endtask

    task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic z);
        op = o; funct = f; zero = z;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] es, input logic [17:0] ee);
        checks++;
        if (state !== es || act !== ee) begin
            errors++;
            $display("[TB] FAIL %s: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                     tag, state, act, es, ee);
        end
    endtask

    initial begin
        addRtype(6'b100001, 4'b0000);   // addu
        addRtype(6'b100011, 4'b0001);   // subu
        addRtype(6'b100100, 4'b0011);   // and
        addRtype(6'b100101, 4'b0010);   // or
        addRtype(6'b101010, 4'b0100);   // slt
        addImm(6'b001101, 4'b0010, 2'b00);  // ori
        addImm(6'b001001, 4'b0000, 2'b01);  // addiu
        addImm(6'b001111, 4'b0010, 2'b10);  // lui
        // lw
        addFetchDcd(6'b100011, 6'b0, 1'b0);
        add(6'b100011, 6'b0, 1'b0, 4'd4, pk(0, 0, 0, 0, 2'b00, 4'b0000, 1, 2'b01, 2'b00, 2'b00, 0));
        add(6'b100011, 6'b0, 1'b0, 4'd5, NZ);
        add(6'b100011, 6'b0, 1'b0, 4'd6, pk(0, 0, 1, 0, 2'b00, 4'b0000, 0, 2'b00, 2'b10, 2'b01, 0));
        // sw
        addFetchDcd(6'b101011, 6'b0, 1'b0);
        add(6'b101011, 6'b0, 1'b0, 4'd4, pk(0, 0, 0, 0, 2'b00, 4'b0000, 1, 2'b01, 2'b00, 2'b00, 0));
        add(6'b101011, 6'b0, 1'b0, 4'd7, pk(0, 0, 0, 1, 2'b00, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 0));
        // beq taken / not taken
        addFetchDcd(6'b000100, 6'b0, 1'b1);
        add(6'b000100, 6'b0, 1'b1, 4'd8, pk(1, 0, 0, 0, 2'b01, 4'b0001, 0, 2'b00, 2'b00, 2'b00, 0));
        addFetchDcd(6'b000100, 6'b0, 1'b0);
        add(6'b000100, 6'b0, 1'b0, 4'd8, pk(0, 0, 0, 0, 2'b01, 4'b0001, 0, 2'b00, 2'b00, 2'b00, 0));
        // j, jal, jr
        addFetchDcd(6'b000010, 6'b0, 1'b0);
        add(6'b000010, 6'b0, 1'b0, 4'd9, pk(1, 0, 0, 0, 2'b10, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 0));
        addFetchDcd(6'b000011, 6'b0, 1'b0);
        add(6'b000011, 6'b0, 1'b0, 4'd10, pk(1, 0, 1, 0, 2'b10, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 0));
        addFetchDcd(6'b000000, 6'b001000, 1'b0);
        add(6'b000000, 6'b001000, 1'b0, 4'd11, pk(1, 0, 0, 0, 2'b11, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 0));
        // illegal opcode, then illegal R-type funct
        add(6'b111111, 6'b0, 1'b0, 4'd0, FE);
        add(6'b111111, 6'b0, 1'b0, 4'd1, pk(0, 0, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 1));
        add(6'b000000, 6'b000000, 1'b0, 4'd0, FE);
        add(6'b000000, 6'b000000, 1'b0, 4'd1, pk(0, 0, 0, 0, 2'b00, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 1));

        rst = 1'b1;
        applyStimulus(6'b000000, 6'b000000, 1'b0);
        #1 rst = 1'b0;
        #1 checkOutput("reset_async", 4'd0, NZ);
        @(posedge clk);
        #1 checkOutput("reset_held_edge", 4'd0, NZ);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].funct, vecs[i].zero);
            #1 checkOutput($sformatf("vec%0d_op%b_fn%b", i, vecs[i].op, vecs[i].funct),
                           vecs[i].st, vecs[i].exp);
            @(negedge clk);
        end

        // sw aborted by reset while in MW
        applyStimulus(6'b101011, 6'b0, 1'b0);
        #1 checkOutput("sw_fetch", 4'd0, FE);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1 checkOutput("sw_mw", 4'd7, pk(0, 0, 0, 1, 2'b00, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 0));
        rst = 1'b0;
        #1 checkOutput("sw_abort_async", 4'd0, NZ);
        @(negedge clk);
        rst = 1'b1;
        #1 checkOutput("after_release_fetch", 4'd0, FE);
        @(posedge clk);
        #1 checkOutput("after_release_dcd", 4'd1, NZ);

        // lw aborted by reset while in MR
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(6'b100011, 6'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1 checkOutput("lw_mr", 4'd5, NZ);
        rst = 1'b0;
        #1 checkOutput("lw_abort_async", 4'd0, NZ);
        @(posedge clk);
        #1 checkOutput("lw_abort_no_lwb", 4'd0, NZ);
        @(negedge clk);
        rst = 1'b1;
        #1 checkOutput("lw_release_fetch", 4'd0, FE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst; rst low forces reset immediately, independent of clk.
REQ-002 clk  input  1  system clock; all state changes SHALL occur on its rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 op  input  6  instruction opcode, IR[31:26], from the datapath.
REQ-005 funct  input  6  R-type function field, IR[5:0].
REQ-006 zero  input  1  ALU equality flag, combinational in the current cycle.
REQ-007 PCWr, IRWr, RFWr, wren  output  1 each  write enables for PC, IR, register file and data memory.
REQ-008 npcop  output  2  next-PC select: 00 PC+4, 01 branch, 10 j/jal target, 11 jr (rs).
REQ-009 aluop  output  4  ALU operation: 0000 addu, 0001 subu, 0010 or, 0011 and, 0100 slt.
REQ-010 sel  output  1  ALU B operand: 0 register B, 1 Imm32.
REQ-011 extop  output  2  immediate extension: 00 zero-extend, 01 sign-extend, 10 lui (imm<<16).
REQ-012 D_sel  output  2  RF write data: 00 pc, 01 DL, 10 DM.
REQ-013 R_sel  output  2  RF destination: 00 $31, 01 rt, 10 rd.
REQ-014 state  output  4  current FSM state, for debug.
REQ-015 illegal  output  1  one-cycle pulse on an unsupported opcode or funct.

Function
REQ-016 The FSM SHALL have these states and encodings: FETCH=0, DCD=1, EXE=2, WB=3, MA=4, MR=5, LWB=6, MW=7, BR=8, JMP=9, JAL=10, JR=11.
REQ-017 Every output SHALL be a combinational decode of state, op, funct and zero; any output not listed for a state SHALL be 0.
REQ-018 FETCH SHALL drive IRWr=1, PCWr=1, npcop=00, and go to DCD.
REQ-019 DCD SHALL route the instruction as follows:
- R-type (op 000000) with funct addu 100001, subu 100011, and 100100, or 100101, or slt 101010 -> EXE.
- jr (op 000000, funct 001000) -> JR.
- ori 001101, addiu 001001, lui 001111 -> EXE.
- lw 100011, sw 101011 -> MA.
- beq 000100 -> BR.
- j 000010 -> JMP.
- jal 000011 -> JAL.
- Anything else -> FETCH, with illegal=1 for that cycle.
REQ-020 EXE SHALL drive the R-type aluop from funct with sel=0; ori SHALL use aluop or, sel=1, extop=00; addiu SHALL use addu, sel=1, extop=01; lui SHALL use or, sel=1, extop=10; EXE SHALL then go to WB.
REQ-021 WB SHALL keep the EXE ALU controls and drive RFWr=1 and D_sel=01; R_sel SHALL be 10 for R-type and 01 for immediates; WB SHALL then go to FETCH.
REQ-022 MA SHALL drive aluop=addu, sel=1, extop=01, then go to MR for lw or MW for sw.
REQ-023 MR SHALL drive no enables and go to LWB; LWB SHALL drive RFWr=1, D_sel=10, R_sel=01, then go to FETCH.
REQ-024 MW SHALL drive wren=1 and sel=0 (register B onto DM din), then go to FETCH.
REQ-025 BR SHALL drive aluop=subu, sel=0, npcop=01, PCWr=zero, then go to FETCH.
REQ-026 JMP SHALL drive PCWr=1, npcop=10, then go to FETCH.
REQ-027 JR SHALL drive PCWr=1, npcop=11, then go to FETCH.
REQ-028 JAL SHALL drive RFWr=1, R_sel=00, D_sel=00 (the already-incremented PC), PCWr=1, npcop=10, then go to FETCH.
REQ-029 Latency in cycles SHALL be: R-type and immediates 4, lw 5, sw 4, beq/j/jr/jal 3, illegal 2.
REQ-030 An unused state encoding SHALL go to FETCH on the next edge with all enables 0.

Reset
REQ-031 While rst=0, state SHALL be FETCH and PCWr, IRWr, RFWr, wren and illegal SHALL all be 0; the other outputs SHALL be 0.
REQ-032 The first rising edge after rst rises SHALL be evaluated in FETCH with normal outputs.
REQ-033 rst asserted in any state, including mid-lw or in MW, SHALL abort the instruction with no further writes.

Verification
REQ-034 addu (op 0, funct 100001) -> FETCH, DCD, EXE, WB; in WB RFWr=1, R_sel=10, D_sel=01, aluop=0000.
REQ-035 lw (op 100011) -> states 0,1,4,5,6; RFWr only in LWB, with D_sel=10 and R_sel=01; wren stays 0 throughout.
REQ-036 beq with zero=1 -> PCWr=1, npcop=01 in BR; with zero=0 -> PCWr=0; both cases return to FETCH after 3 cycles.
REQ-037 jal -> JAL cycle has RFWr=1, R_sel=00, D_sel=00, PCWr=1, npcop=10; op 111111 -> illegal=1 in DCD, then FETCH.
REQ-038 sw with rst pulled low during MW -> wren drops to 0 immediately and state=0; after release, the next edge asserts IRWr=1.
